// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB core.
// Handles load-use and JR-operand stalls, taken-branch and jump flushes, and
// freezes the pipeline while a data-memory access is outstanding. A watchdog
// drops into a sticky ERROR state if memory never answers.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters. Without it, stall_cnt and flush_cnt are tied to 0.
module hazard_sequencer #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_j,
  input  logic              id_call,
  input  logic              id_jr,
  input  logic              ex_mem_read,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic              err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Wait counter only needs to reach TIMEOUT (at most 255).
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;

  logic lu_hit;
  logic jr_hit;
  logic jmp_hit;
  logic run_rules;

  // Hazard detection on the ID/EX decode fields; register 0 is compared like any other.
  always_comb begin
    lu_hit  = id_valid && ex_mem_read &&
              ((id_use1 && (id_src1 == ex_dest)) || (id_use2 && (id_src2 == ex_dest)));
    jr_hit  = id_valid && id_jr && ex_wr && (id_src1 == ex_dest);
    jmp_hit = id_valid && (id_j || id_call || id_jr);
  end

  assign wait_inc = wait_q + WAIT_ONE;

  // Next state, wait counter and combinational stage controls.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    run_rules   = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    err         = 1'b0;

    if (reset) begin
      state_d     = ST_RUN;
      wait_d      = '0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            wait_d  = WAIT_ONE;
            state_d = (WAIT_ONE == TIMEOUT_V) ? ST_ERROR : ST_MEM_WAIT;
          end else begin
            run_rules = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready) begin
            wait_d = wait_inc;
            if (wait_inc == TIMEOUT_V) begin
              state_d = ST_ERROR;
            end
          end else begin
            // Release cycle: hazards held in the frozen stages resolve now.
            run_rules = 1'b1;
            wait_d    = '0;
            state_d   = ST_RUN;
          end
        end
        ST_ERROR: begin
          err = 1'b1;
        end
        default: begin
          state_d = ST_ERROR;
          err     = 1'b1;
        end
      endcase

      if (run_rules) begin
        if (ex_branch_taken) begin
          // ID instruction is being killed, so its stalls are moot.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu_hit || jr_hit) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (jmp_hit) begin
          ifid_flush = 1'b1;
        end
      end else begin
        // Freeze (MEM_WAIT entry/hold) and ERROR look identical on the controls.
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: stalled-PC cycles and IF/ID or ID/EX flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((ifid_flush || idex_flush) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
